// File: rtl/parity_frame_arbiter.sv
// Round-robin share of one serial parity checker; result 5 cycles after grant, one frame per FRAME_W+4 cycles.
// req is ignored while busy (hold until gnt). Optional PARITY_SELFCHECK_EN adds sticky chk_err output.
module parity_frame_arbiter #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 3,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] data,
  output logic [NREQ-1:0]         gnt,
  output logic                    chk_reset,
  output logic                    chk_inp,
  input  logic                    chk_out,
  output logic                    res_valid,
  output logic                    res_pbit,
  output logic [IDW-1:0]          res_id,
  output logic                    busy
`ifdef PARITY_SELFCHECK_EN
  ,
  output logic                    chk_err
`endif
);

  localparam int CW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, SHIFT, SAMPLE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_nxt;
  logic [IDW-1:0]       rr_q;
  logic [IDW-1:0]       id_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [NREQ-1:0]      gnt_q;
  logic                 chk_inp_q;
  logic                 res_pbit_q;
  logic [IDW-1:0]       res_id_q;
  logic                 any_req;
  logic [IDW-1:0]       win_id;
  logic [FRAME_W-1:0]   win_frame;
  logic                 last_bit;

  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NREQ;
    return IDW'(s);
  endfunction

  // Scan downwards so the last hit written is the first in rr_q order.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rot_idx(rr_q, i)]) begin
        any_req = 1'b1;
        win_id  = rot_idx(rr_q, i);
      end
    end
  end

  always_comb begin
    win_frame = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win_id) win_frame = data[j*FRAME_W +: FRAME_W];
    end
  end

  assign cnt_nxt  = cnt_q + 1'b1;
  assign last_bit = (cnt_q == CW'(FRAME_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SYNC;
      SYNC:    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = SAMPLE;
      SAMPLE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    chk_reset = reset | (state_q == SYNC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q      <= '0;
      rr_q       <= '0;
      id_q       <= '0;
      frame_q    <= '0;
      cnt_q      <= '0;
      chk_inp_q  <= 1'b0;
      res_pbit_q <= 1'b0;
      res_id_q   <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q   <= NREQ'(1) << win_id;
          frame_q <= win_frame;
          id_q    <= win_id;
          rr_q    <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end
        SYNC: begin
          cnt_q     <= '0;
          chk_inp_q <= frame_q[0];
        end
        SHIFT: begin
          if (last_bit) begin
            chk_inp_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_nxt;
            chk_inp_q <= frame_q[cnt_nxt];
          end
        end
        // Checker output has settled one cycle after the last shifted bit.
        SAMPLE: begin
          res_pbit_q <= chk_out;
          res_id_q   <= id_q;
        end
        default: ;
      endcase
    end
  end

`ifdef PARITY_SELFCHECK_EN
  logic chk_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       chk_err_q <= 1'b0;
    else if (state_q == DONE && chk_out != ~^frame_q) chk_err_q <= 1'b1;
  end
  assign chk_err = chk_err_q;
`endif

  assign gnt      = gnt_q;
  assign chk_inp  = chk_inp_q;
  assign res_pbit = res_pbit_q;
  assign res_id   = res_id_q;

endmodule
